// File: rtl/dircc_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : dircc_mem_stream_reader
// Description : Reads a run of halfwords from a 16-bit memory port and emits
//               them as a sop/eop-framed stream through a 2-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module dircc_mem_stream_reader #(
    parameter int MEM_WORDS = 20480,
    parameter int ADDR_W    = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [ADDR_W:0]   i_cmd_len,
    output logic [ADDR_W-1:0] o_address2,
    output logic              o_chipselect2,
    output logic              o_clken2,
    output logic              o_write2,
    output logic [1:0]        o_byteenable2,
    output logic [15:0]       o_writedata2,
    input  logic [15:0]       i_readdata2,
    output logic              o_st_valid,
    input  logic              i_st_ready,
    output logic [15:0]       o_st_data,
    output logic              o_st_sop,
    output logic              o_st_eop,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   c_MEM_WORDS = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [ADDR_W:0]   c_ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issue_cnt;

    // Read issued last cycle: its data is on i_readdata2 this cycle.
    logic              r_pend;
    logic              r_pend_sop;
    logic              r_pend_eop;

    logic [17:0]       r_fifo [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_st_valid;
    logic              w_pop;
    logic [2:0]        w_occ_after;
    logic [2:0]        w_left;
    logic              w_issue;
    logic              w_first;
    logic              w_last;
    logic              w_accept;
    logic [ADDR_W:0]   w_len_clamped;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [17:0]       w_head;

    assign w_st_valid    = (r_count != 2'd0);
    assign w_pop         = w_st_valid & i_st_ready;
    assign w_occ_after   = {1'b0, r_count} - {2'b00, w_pop};
    assign w_left        = w_occ_after + {2'b00, r_pend};
    // Occupancy is counted after this cycle's pop so one read per cycle can
    // be sustained while at most two halfwords are buffered or in flight.
    assign w_issue       = (r_state == S_READ) && (w_left < 3'd2);
    assign w_first       = (r_issue_cnt == '0);
    assign w_last        = (r_issue_cnt == (r_len - c_ONE));
    assign w_accept      = r_cmd_ready & i_cmd_valid;
    assign w_len_clamped = (i_cmd_len > c_MEM_WORDS) ? c_MEM_WORDS : i_cmd_len;
    assign w_addr_inc    = (r_addr == c_LAST_ADDR) ? '0 : (r_addr + 1'b1);
    assign w_head        = r_fifo[r_rptr];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= i_cmd_addr;
                        r_len       <= w_len_clamped;
                        r_issue_cnt <= '0;
                        if (w_len_clamped == '0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr      <= w_addr_inc;
                        r_issue_cnt <= r_issue_cnt + c_ONE;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_left == 3'd0) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend     <= 1'b0;
            r_pend_sop <= 1'b0;
            r_pend_eop <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_pend     <= w_issue;
            r_pend_sop <= w_issue & w_first;
            r_pend_eop <= w_issue & w_last;
            if (r_pend) begin
                r_fifo[r_wptr] <= {i_readdata2, r_pend_sop, r_pend_eop};
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_address2    = r_addr;
    assign o_chipselect2 = w_issue;
    assign o_clken2      = w_issue;
    assign o_write2      = 1'b0;
    assign o_byteenable2 = 2'b11;
    assign o_writedata2  = 16'h0000;
    assign o_st_valid    = w_st_valid;
    assign o_st_data     = w_head[17:2];
    assign o_st_sop      = w_st_valid & w_head[1];
    assign o_st_eop      = w_st_valid & w_head[0];
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dircc_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dircc_mem_stream_reader
// Description : Randomized self-checking bench against a beat-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dircc_mem_stream_reader;

    localparam int MEM_WORDS = 20480;
    localparam int ADDR_W    = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic [ADDR_W-1:0] address2;
    logic              chipselect2;
    logic              clken2;
    logic              write2;
    logic [1:0]        byteenable2;
    logic [15:0]       writedata2;
    logic [15:0]       readdata2 = 16'h0000;
    logic              st_valid;
    logic              st_ready;
    logic [15:0]       st_data;
    logic              st_sop;
    logic              st_eop;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    dircc_mem_stream_reader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_len     (cmd_len),
        .o_address2    (address2),
        .o_chipselect2 (chipselect2),
        .o_clken2      (clken2),
        .o_write2      (write2),
        .o_byteenable2 (byteenable2),
        .o_writedata2  (writedata2),
        .i_readdata2   (readdata2),
        .o_st_valid    (st_valid),
        .i_st_ready    (st_ready),
        .o_st_data     (st_data),
        .o_st_sop      (st_sop),
        .o_st_eop      (st_eop),
        .o_busy        (busy),
        .o_done        (done)
    );

    function automatic logic [15:0] mem_val(input int a);
        return 16'(32'hA000 + a);
    endfunction

    // Memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        readdata2 <= (chipselect2 && clken2) ? mem_val(int'(address2)) : 16'($urandom);
    end

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       exp_q[$];
    int          addr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          inflight = 0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_vec = '0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (n % 2 == 0);
        return ($urandom % 4) != 0;
    endfunction

    // Called at the falling edge: checks memory strobes and stream beats.
    task automatic sample_cycle(output logic beat, output logic eop);
        beat_t e;
        beat = 1'b0;
        eop  = 1'b0;
        chk_eq("clken_eq_cs", clken2, chipselect2);
        chk_eq("write_port_tied", {write2, writedata2, byteenable2}, {1'b0, 16'h0000, 2'b11});
        if (chipselect2) begin
            inflight++;
            if (addr_q.size() == 0) chk_eq("extra_read", 1, 0);
            else chk_eq("rd_addr", address2, addr_q.pop_front());
        end
        if (prev_stall) chk_eq("stall_hold", {st_valid, st_sop, st_eop, st_data}, prev_vec);
        if (st_valid && st_ready) begin
            beat = 1'b1;
            eop  = st_eop;
            inflight--;
            if (exp_q.size() == 0) chk_eq("extra_beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk_eq("beat_data", st_data, e.d);
                chk_eq("beat_sop", st_sop, e.sop);
                chk_eq("beat_eop", st_eop, e.eop);
            end
        end
        chk_eq("outstanding_le2", (inflight <= 2), 1);
        prev_stall = st_valid && !st_ready;
        prev_vec   = {st_valid, st_sop, st_eop, st_data};
    endtask

    // Entered at a falling edge; returns just after the accepting edge.
    task automatic issue_cmd(input int addr, input int len, output int L);
        int w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk_eq("cmd_ready_idle", cmd_ready, 1);
        L = (len > MEM_WORDS) ? MEM_WORDS : len;
        for (int i = 0; i < L; i++) begin
            exp_q.push_back('{d: mem_val((addr + i) % MEM_WORDS), sop: (i == 0), eop: (i == L - 1)});
            addr_q.push_back((addr + i) % MEM_WORDS);
        end
        cmd_valid = 1'b1;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = (ADDR_W+1)'(len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = ADDR_W'($urandom);
        cmd_len   = (ADDR_W+1)'($urandom);
    endtask

    task automatic finish_cmd(input int L, input int mode);
        logic beat, eop, done_seen;
        int   eop_cyc, exp_done;
        done_seen = 1'b0;
        eop_cyc   = -1;
        for (int n = 0; n < 4 * L + 20 && !done_seen; n++) begin
            st_ready = ready_for(mode, n);
            @(negedge clk);
            sample_cycle(beat, eop);
            if (eop) eop_cyc = n;
            if (n == 0) chk_eq("cs_after_accept", chipselect2, (L > 0));
            if (n == 1) chk_eq("valid_cycle1", st_valid, 0);
            if (n == 2 && L > 0) chk_eq("valid_cycle2", st_valid, 1);
            if (done) begin
                done_seen = 1'b1;
                exp_done  = (L == 0) ? 0 : ((mode == 0) ? L + 2 : eop_cyc + 1);
                chk_eq("done_cycle", n, exp_done);
                chk_eq("busy_at_done", busy, 0);
            end else begin
                chk_eq("busy_until_done", busy, (L > 0));
            end
            @(posedge clk);
            #1;
        end
        if (!done_seen) chk_eq("done_timeout", 0, 1);
        @(negedge clk);
        sample_cycle(beat, eop);
        chk_eq("ready_after_done", cmd_ready, 1);
        chk_eq("done_one_pulse", done, 0);
        chk_eq("beats_left", exp_q.size(), 0);
        chk_eq("reads_left", addr_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk_eq({tag, "_ctrl"}, {cmd_ready, chipselect2, clken2, st_valid, st_sop, st_eop, busy, done}, 0);
        chk_eq({tag, "_addr"}, address2, 0);
        chk_eq({tag, "_data"}, st_data, 0);
    endtask

    initial begin
        int   L, beats;
        logic beat, eop;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        st_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_eq("ready_after_reset", cmd_ready, 1);

        issue_cmd(16'h0010, 4, L);       finish_cmd(L, 0);
        issue_cmd(20478, 4, L);          finish_cmd(L, 0);
        issue_cmd(300, 8, L);            finish_cmd(L, 1);
        issue_cmd(77, 0, L);             finish_cmd(L, 0);
        issue_cmd(20479, 1, L);          finish_cmd(L, 0);
        issue_cmd(5, MEM_WORDS + 1, L);  finish_cmd(L, 0);
        for (int k = 0; k < 12; k++) begin
            issue_cmd(int'($urandom_range(0, MEM_WORDS - 1)), int'($urandom_range(0, 20)), L);
            finish_cmd(L, 2);
        end

        // Abort a 10-beat command after its third beat.
        issue_cmd(20475, 10, L);
        beats = 0;
        for (int n = 0; n < 40 && beats < 3; n++) begin
            st_ready = 1'b1;
            @(negedge clk);
            sample_cycle(beat, eop);
            if (beat) beats++;
            if (beats < 3) begin
                @(posedge clk);
                #1;
            end
        end
        chk_eq("beats_before_abort", beats, 3);
        #2 reset = 1'b1;
        #1 check_reset_vals("abort");
        repeat (2) @(negedge clk);
        check_reset_vals("abort_hold");
        exp_q.delete();
        addr_q.delete();
        inflight   = 0;
        prev_stall = 1'b0;
        reset = 1'b0;
        chk_eq("ready_low_at_release", cmd_ready, 0);
        @(negedge clk);
        issue_cmd(1234, 6, L);
        finish_cmd(L, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dircc_mem_stream_reader.md
DIRCC_MEM_STREAM_READER -- requirements
Module: dircc_mem_stream_reader

Interface
REQ-001 Parameter MEM_WORDS, default 20480, halfword depth of the 16-bit memory port; addresses wrap modulo MEM_WORDS.
REQ-002 Parameter ADDR_W, default 15, width of memory address and command fields.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready on a rising edge.
REQ-007 cmd_addr  input  ADDR_W  start halfword address.
REQ-008 cmd_len  input  ADDR_W+1  halfword count, 0..MEM_WORDS.
REQ-009 address2  output  ADDR_W  memory port-2 address.
REQ-010 chipselect2  output  1  memory port-2 read strobe.
REQ-011 clken2  output  1  memory port-2 clock enable.
REQ-012 write2  output  1  tied 0.
REQ-013 byteenable2  output  2  tied 2'b11.
REQ-014 writedata2  output  16  tied 0.
REQ-015 readdata2  input  16  memory read data, valid exactly 1 cycle after a read strobe.
REQ-016 st_valid  output  1  stream source valid.
REQ-017 st_ready  input  1  stream sink ready; transfer when st_valid & st_ready.
REQ-018 st_data  output  16  stream halfword.
REQ-019 st_sop  output  1  high with the first halfword of a command.
REQ-020 st_eop  output  1  high with the last halfword of a command.
REQ-021 busy  output  1  high from command accept until done.
REQ-022 done  output  1  one-cycle pulse at command completion.

Function
REQ-023 FSM states IDLE, READ, DRAIN, FINISH; IDLE->READ on accept with cmd_len>0; IDLE->FINISH on accept with cmd_len=0; READ->DRAIN after last read issued; DRAIN->FINISH when buffer empty and no read in flight; FINISH->IDLE unconditionally.
REQ-024 cmd_ready high only in IDLE; commands presented in other states are ignored until IDLE.
REQ-025 Read issue: chipselect2=clken2=1 for one cycle per halfword; issue only when (buffer occupancy + in-flight reads) < 2.
REQ-026 Read buffer: 2-entry FIFO capturing readdata2 in the cycle after each issue; never overflows, never drops data.
REQ-027 address2 starts at cmd_addr and increments by 1 per issued read; value MEM_WORDS-1 is followed by 0.
REQ-028 Throughput: with st_ready held high, one halfword per cycle sustained; first st_valid 2 cycles after command accept.
REQ-029 st_valid = FIFO not empty; st_data/st_sop/st_eop from FIFO head; held stable while st_valid & ~st_ready.
REQ-030 st_sop set on halfword index 0, st_eop on index cmd_len-1; both set for cmd_len=1.
REQ-031 cmd_len=0: no read issued, no stream beat, done pulses 1 cycle after accept.
REQ-032 done asserted in FINISH only, i.e., the cycle after the eop beat transfers; busy deasserts with done.
REQ-033 Halfword counters ADDR_W+1 bits; cmd_len above MEM_WORDS is clamped to MEM_WORDS.
REQ-034 chipselect2 and clken2 0 whenever no read issues; write2 never asserted.

Reset
REQ-035 During reset, and at the first edge after release: state IDLE, cmd_ready=0 while reset high then 1, chipselect2=0, clken2=0, address2=0, st_valid=0, st_sop=0, st_eop=0, st_data=0, busy=0, done=0, FIFO empty.
REQ-036 Reset mid-transfer aborts immediately: in-flight read data discarded, no done pulse, no eop emitted.

Verification
REQ-037 cmd_addr=0x0010, cmd_len=4, st_ready=1, memory preloaded 0xA000+addr -> beats 0xA010..0xA013 on consecutive cycles, sop on first, eop on fourth, done 1 cycle after eop.
REQ-038 cmd_addr=20478, cmd_len=4 -> address2 sequence 20478,20479,0,1; data order matches.
REQ-039 cmd_len=8, st_ready toggling 1/0 each cycle -> 8 beats, no loss or duplication, st_data stable during stalls, never more than 2 reads outstanding+buffered.
REQ-040 cmd_len=0 -> no chipselect2, no st_valid, done pulse 1 cycle after accept, cmd_ready high again next cycle.
REQ-041 cmd_len=1 -> single beat with sop=eop=1.
REQ-042 Assert reset after 3 of 10 beats -> all outputs at reset values within the same cycle, new command accepted after release.
